// File: rtl/imm_extend_pipe.sv
// Registered, flow-controlled immediate extractor with a 2-entry skid buffer.
// Optional build macro IMM_SCALE_EN adds in_scale and left-shifts the extended value.
module imm_extend_pipe #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [2:0]        in_mode,
`ifdef IMM_SCALE_EN
  input  logic [1:0]        in_scale,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic [15:0]       out_count
);

  localparam int NIB = DATA_W / 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] m_q, m_d;
  logic [DATA_W-1:0] s_q, s_d;
  logic [15:0]       count_q, count_d;
  logic [DATA_W-1:0] ext_s;
  logic              accept_s;
  logic              deliver_s;

  // mode[2] set forces a zero fill; otherwise the field MSB is replicated
  function automatic logic [DATA_W-1:0] extend_field(
    input logic [DATA_W-1:0] instr,
    input logic [2:0]        mode
  );
    logic [DATA_W-1:0] r;
    logic              fill;
    case (mode[1:0])
      2'b00: begin
        fill = ~mode[2] & instr[2*NIB-1];
        r    = {{(DATA_W-NIB){fill}}, instr[2*NIB-1:NIB]};
      end
      2'b01: begin
        fill = ~mode[2] & instr[NIB-1];
        r    = {{(DATA_W-NIB){fill}}, instr[NIB-1:0]};
      end
      2'b10: begin
        fill = ~mode[2] & instr[2*NIB-1];
        r    = {{(DATA_W-2*NIB){fill}}, instr[2*NIB-1:0]};
      end
      2'b11: begin
        fill = ~mode[2] & instr[3*NIB-1];
        r    = {{(DATA_W-3*NIB){fill}}, instr[3*NIB-1:0]};
      end
      default: begin
        fill = 1'b0;
        r    = {DATA_W{1'b0}};
      end
    endcase
    return r;
  endfunction

  // Extended (and optionally scaled) value presented to the storage registers
  always_comb begin
`ifdef IMM_SCALE_EN
    ext_s = extend_field(in_instr, in_mode) << in_scale;
`else
    ext_s = extend_field(in_instr, in_mode);
`endif
  end

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_imm   = m_q;
  assign out_count = count_q;
  assign accept_s  = in_valid & in_ready;
  assign deliver_s = out_valid & out_ready;

  // Next-state and register-load selection for the M/S skid pair
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          m_d     = ext_s;
          state_d = ST_ONE;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && out_ready) begin
          m_d = ext_s;
        end else if (accept_s) begin
          s_d     = ext_s;
          state_d = ST_FULL;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          m_d     = s_q;
          state_d = ST_ONE;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Delivered-word counter, wraps naturally at 16 bits
  always_comb begin
    if (deliver_s) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  // State and data registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      m_q     <= {DATA_W{1'b0}};
      s_q     <= {DATA_W{1'b0}};
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_imm_extend_pipe;

  localparam int W = 16;
  localparam int N = W / 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_instr;
  logic [2:0]    in_mode;
  logic [1:0]    scale_s;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_imm;
  logic [15:0]   out_count;

  int checks;
  int errors;
  int exp_count;
  logic [W-1:0] q[$];

  typedef struct {
    logic [W-1:0] instr;
    logic [2:0]   mode;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tab[8];

  imm_extend_pipe #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_mode   (in_mode),
`ifdef IMM_SCALE_EN
    .in_scale  (scale_s),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field value by shift/mask, sign applied arithmetically, then scaled
  function automatic logic [W-1:0] ref_imm(input logic [W-1:0] instr,
                                           input logic [2:0] mode, input int sc);
    int lo;
    int w;
    longint f;
    case (mode[1:0])
      2'd0:    begin lo = N; w = N;     end
      2'd1:    begin lo = 0; w = N;     end
      2'd2:    begin lo = 0; w = 2 * N; end
      default: begin lo = 0; w = 3 * N; end
    endcase
    f = (longint'(instr) >> lo) & ((longint'(1) << w) - 1);
    if (!mode[2] && f >= (longint'(1) << (w - 1))) f = f - (longint'(1) << w);
    f = f << sc;
    return 16'(f);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int eff_scale();
`ifdef IMM_SCALE_EN
    return int'(scale_s);
`else
    return 0;
`endif
  endfunction

  // One clock: model the transfers from the queue, then check DUT after the edge
  task automatic cyc();
    bit do_in;
    bit do_out;
    if (rst) begin
      @(posedge clk);
      #1;
      q.delete();
      exp_count = 0;
    end else begin
      if (q.size() > 0 && out_valid === 1'b1) chk("out_imm", out_imm, q[0]);
      do_out = (q.size() != 0) && out_ready;
      do_in  = in_valid && (q.size() < 2);
      if (do_out) begin
        void'(q.pop_front());
        exp_count++;
      end
      if (do_in) q.push_back(ref_imm(in_instr, in_mode, eff_scale()));
      @(posedge clk);
      #1;
      chk("out_count", out_count, exp_count & 32'hFFFF);
      chk("out_valid", out_valid, q.size() != 0);
      chk("in_ready", in_ready, q.size() < 2);
    end
  endtask

  initial begin
    int c0;
    logic [W-1:0] wa, wb, wc;
    checks = 0; errors = 0; exp_count = 0;
    rst = 1'b1; in_valid = 1'b0; in_instr = 16'h0000; in_mode = 3'b000;
    scale_s = 2'd0; out_ready = 1'b0;
    tab[0] = '{16'h0A8F, 3'b000, 16'hFFF8};
    tab[1] = '{16'h0A8F, 3'b001, 16'hFFFF};
    tab[2] = '{16'h0A8F, 3'b010, 16'hFF8F};
    tab[3] = '{16'h0A8F, 3'b011, 16'hFA8F};
    tab[4] = '{16'h0A8F, 3'b100, 16'h0008};
    tab[5] = '{16'h0A8F, 3'b101, 16'h000F};
    tab[6] = '{16'h0A8F, 3'b110, 16'h008F};
    tab[7] = '{16'h0A8F, 3'b111, 16'h0A8F};

    // Reset state
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_imm", out_imm, 16'h0000);
    chk("rst_out_count", out_count, 16'd0);
    chk("rst_in_ready", in_ready, 1'b1);

    // Extension table, one word per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_instr = tab[i].instr; in_mode = tab[i].mode;
      cyc();
      chk("ext_tab", out_imm, tab[i].exp);
    end
    in_valid = 1'b0;
    cyc();

    // Back-pressure with A, B, C
    wa = 16'h1234; wb = 16'h0F7E; wc = 16'hABCD;
    out_ready = 1'b0; in_mode = 3'b011;
    in_valid = 1'b1; in_instr = wa; cyc();
    in_instr = wb; cyc();
    in_instr = wc; cyc();
    chk("bp_c_held", in_ready, 1'b0);
    chk("bp_a_out", out_imm, ref_imm(wa, 3'b011, 0));
    out_ready = 1'b1; cyc();
    chk("bp_b_out", out_imm, ref_imm(wb, 3'b011, 0));
    chk("bp_c_ready", in_ready, 1'b1);
    cyc();
    chk("bp_c_out", out_imm, ref_imm(wc, 3'b011, 0));
    in_valid = 1'b0; cyc();
    chk("bp_drained", out_valid, 1'b0);

    // Streaming 100 words in 101 cycles
    c0 = exp_count;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_instr = W'($urandom); in_mode = 3'($urandom);
      cyc();
    end
    in_valid = 1'b0; cyc();
    chk("stream_count", out_count, (c0 + 100) & 32'hFFFF);

    // Reset while FULL with a word offered during reset
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 16'h5555; cyc();
    in_instr = 16'h6666; cyc();
    rst = 1'b1; in_instr = 16'h7777; cyc();
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b1);
    chk("mid_rst_count", out_count, 16'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cyc();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      in_instr = W'($urandom); in_mode = 3'($urandom);
`ifdef IMM_SCALE_EN
      scale_s = 2'($urandom_range(0, 3));
`endif
      cyc();
    end
    out_ready = 1'b1; in_valid = 1'b0;
    cyc(); cyc(); cyc();
    scale_s = 2'd0;

`ifdef IMM_SCALE_EN
    in_valid = 1'b1; in_instr = 16'h00F8; in_mode = 3'b010; scale_s = 2'd2;
    cyc();
    chk("scale", out_imm, 16'hFFE0);
    in_valid = 1'b0; scale_s = 2'd0; cyc();
`endif

    // Counter wrap: 65535 transfers, then one more
    rst = 1'b1; cyc(); rst = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; in_mode = 3'b001;
    for (int i = 0; i < 65535; i++) begin
      in_instr = W'(i);
      cyc();
    end
    in_valid = 1'b0; cyc();
    chk("wrap_pre", out_count, 16'hFFFF);
    in_valid = 1'b1; cyc();
    in_valid = 1'b0; cyc();
    chk("wrap_zero", out_count, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
